// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix stream controller: line geometry, the default
// watchdog limit and the controller FSM state encoding.
package matrix_pkg;

    localparam int unsigned LINE_W      = 512;
    localparam int unsigned ELEM_W      = 32;
    localparam int unsigned MAT_DIM     = 4;
    localparam int unsigned TIMEOUT_CYC = 1024;

    typedef enum logic [2:0] {
        StIdleA,
        StLoadB,
        StStart,
        StWait,
        StOut,
        StRearm
    } state_e;

endpackage

// File: rtl/matrix_stream_if.sv
// Operand-line input stream and result-line output stream of the matrix controller.
// The master modport is the controller side: it accepts operand lines and sources
// result lines. The slave modport is the surrounding system.
interface matrix_stream_if #(
    parameter int unsigned LINE_W = matrix_pkg::LINE_W
) ();
    import matrix_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [LINE_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [LINE_W-1:0] out_data;

    modport master (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport slave (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

endinterface

// File: rtl/matrix_stream_ctrl.sv
// Sequencer for an external 4x4 matrix-multiply engine. Accepts an A line then a
// B line, starts the engine, waits for its sticky done flag, presents the product
// on the result stream and re-arms the engine before taking the next job.
// Optional feature: define MATRIX_TIMEOUT_EN to add a watchdog on the engine wait;
// without it the wait is unbounded and timeout_err is tied low.
module matrix_stream_ctrl #(
    parameter int unsigned LINE_W      = matrix_pkg::LINE_W,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = matrix_pkg::TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                reset,
    matrix_stream_if.master     bus,
    output logic [2*LINE_W-1:0] eng_matrix,
    output logic                eng_start,
    output logic                eng_reset_n,
    input  logic                eng_done,
    input  logic [LINE_W-1:0]   eng_result,
    output logic                busy,
    output logic [CNT_W-1:0]    job_count,
    output logic                timeout_err
);
    import matrix_pkg::*;

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    state_e            r_state;
    logic [LINE_W-1:0] r_a;
    logic [LINE_W-1:0] r_b;
    logic [LINE_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_in_ready;
    logic              r_eng_start;
    logic              r_eng_reset_n;
    logic              r_busy;
    logic [CNT_W-1:0]  r_job_count;

`ifdef MATRIX_TIMEOUT_EN
    localparam int unsigned WdogW = $clog2(TIMEOUT_CYC + 1);

    logic [WdogW-1:0] r_wdog;
    logic             r_timeout_err;
`endif

    logic w_in_fire;
    logic w_out_fire;

    assign w_in_fire  = bus.in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & bus.out_ready;

    // Job sequencer; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= StIdleA;
            r_a           <= '0;
            r_b           <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_in_ready    <= 1'b1;
            r_eng_start   <= 1'b0;
            r_eng_reset_n <= 1'b1;
            r_busy        <= 1'b0;
            r_job_count   <= '0;
`ifdef MATRIX_TIMEOUT_EN
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            // Pulses default low and are raised only on the transition that owns them.
            r_eng_start <= 1'b0;
`ifdef MATRIX_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            unique case (r_state)
                StIdleA: begin
                    if (w_in_fire) begin
                        r_a     <= bus.in_data;
                        r_busy  <= 1'b1;
                        r_state <= StLoadB;
                    end
                end
                StLoadB: begin
                    if (w_in_fire) begin
                        r_b         <= bus.in_data;
                        r_in_ready  <= 1'b0;
                        r_eng_start <= 1'b1;
                        r_state     <= StStart;
                    end
                end
                StStart: begin
                    // A done flag seen here is stale and deliberately ignored.
`ifdef MATRIX_TIMEOUT_EN
                    r_wdog  <= '0;
`endif
                    r_state <= StWait;
                end
                StWait: begin
                    if (eng_done) begin
                        r_out_data  <= eng_result;
                        r_out_valid <= 1'b1;
                        r_state     <= StOut;
                    end
`ifdef MATRIX_TIMEOUT_EN
                    else if (r_wdog == WdogW'(TIMEOUT_CYC - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_eng_reset_n <= 1'b0;
                        r_state       <= StRearm;
                    end else begin
                        r_wdog <= r_wdog + WdogW'(1);
                    end
`endif
                end
                StOut: begin
                    if (w_out_fire) begin
                        r_out_valid   <= 1'b0;
                        r_job_count   <= r_job_count + CNT_W'(1);
                        r_eng_reset_n <= 1'b0;
                        r_state       <= StRearm;
                    end
                end
                StRearm: begin
                    r_eng_reset_n <= 1'b1;
                    r_in_ready    <= 1'b1;
                    r_busy        <= 1'b0;
                    r_state       <= StIdleA;
                end
                default: begin
                    r_out_valid   <= 1'b0;
                    r_eng_reset_n <= 1'b1;
                    r_in_ready    <= 1'b1;
                    r_busy        <= 1'b0;
                    r_state       <= StIdleA;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

    // A/B only change while loading, so the engine operands stay stable for the whole job.
    assign eng_matrix  = {r_b, r_a};
    assign eng_start   = r_eng_start;
    // The engine is also held in re-arm for as long as the controller is in reset.
    assign eng_reset_n = r_eng_reset_n & reset;
    assign busy        = r_busy;
    assign job_count   = r_job_count;

`ifdef MATRIX_TIMEOUT_EN
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_stream_ctrl.sv
// Self-checking bench for matrix_stream_ctrl with a behavioural stub engine.
// Honours MATRIX_TIMEOUT_EN the same way as the design.
module tb_matrix_stream_ctrl;
    import matrix_pkg::*;

    localparam int unsigned LW = 512;
    // Narrow job counter so the wrap is reachable in a handful of jobs.
    localparam int unsigned CW = 4;
    localparam int unsigned TO = 8;

    logic            clk;
    logic            reset;
    logic [2*LW-1:0] eng_matrix;
    logic            eng_start;
    logic            eng_reset_n;
    logic            eng_done;
    logic [LW-1:0]   eng_result;
    logic            busy;
    logic [CW-1:0]   job_count;
    logic            timeout_err;

    matrix_stream_if #(.LINE_W(LW)) bus ();

    matrix_stream_ctrl #(
        .LINE_W      (LW),
        .CNT_W       (CW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .eng_matrix  (eng_matrix),
        .eng_start   (eng_start),
        .eng_reset_n (eng_reset_n),
        .eng_done    (eng_done),
        .eng_result  (eng_result),
        .busy        (busy),
        .job_count   (job_count),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [LW-1:0] got,
                            input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] matmul(input logic [LW-1:0] a, input logic [LW-1:0] b);
        logic [LW-1:0] p;
        logic [31:0]   acc;
        p = '0;
        for (int r = 0; r < MAT_DIM; r++) begin
            for (int c = 0; c < MAT_DIM; c++) begin
                acc = '0;
                for (int k = 0; k < MAT_DIM; k++) begin
                    acc = acc + a[(r*MAT_DIM+k)*ELEM_W +: ELEM_W] * b[(k*MAT_DIM+c)*ELEM_W +: ELEM_W];
                end
                p[(r*MAT_DIM+c)*ELEM_W +: ELEM_W] = acc;
            end
        end
        return p;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom_range(0, 1000);
        return l;
    endfunction

    // Stub engine: sticky done after eng_lat cycles, cleared by eng_reset_n.
    int            eng_lat;
    bit            hang;
    bit            glitch;
    int            stub_cnt;
    logic          stub_done;
    logic [LW-1:0] stub_prod;

    always @(posedge clk) begin
        if (!eng_reset_n) begin
            stub_done <= 1'b0;
            stub_cnt  <= 0;
        end else if (eng_start) begin
            stub_prod <= matmul(eng_matrix[LW-1:0], eng_matrix[2*LW-1:LW]);
            stub_cnt  <= eng_lat;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1 && !hang) stub_done <= 1'b1;
        end
    end

    // Optional stale done (with garbage result) during the start cycle.
    assign eng_done   = stub_done | (glitch & eng_start);
    assign eng_result = (glitch && eng_start) ? {16{32'hDEAD_BEEF}} : stub_prod;

    // Scoreboard: products of accepted A/B pairs queued, popped on each result handshake.
    logic [LW-1:0] sb[$];
    logic [LW-1:0] a_hold;
    logic [LW-1:0] last_out;
    logic [LW-1:0] exp_line;
    bit            b_phase;
    int            exp_jobs;

    initial begin
        b_phase  = 1'b0;
        exp_jobs = 0;
        last_out = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sb.delete();
                b_phase  = 1'b0;
                exp_jobs = 0;
            end else begin
                if (bus.in_valid && bus.in_ready) begin
                    if (!b_phase) a_hold = bus.in_data;
                    else sb.push_back(matmul(a_hold, bus.in_data));
                    b_phase = ~b_phase;
                end
                if (timeout_err && sb.size() > 0) exp_line = sb.pop_front();
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        check_eq("sb_underflow", LW'(sb.size()), LW'(1));
                    end else begin
                        exp_line = sb.pop_front();
                        check_eq("out_data", bus.out_data, exp_line);
                    end
                    last_out = bus.out_data;
                    check_eq("job_count_pre", LW'(job_count), LW'(exp_jobs));
                    exp_jobs = (exp_jobs + 1) % (1 << CW);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_line(input logic [LW-1:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check_eq("in_ready_wait", LW'(bus.in_ready), LW'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    // Called at a negedge before the result handshake; returns at posedge+1 in idle.
    task automatic finish_job(input logic [LW-1:0] a, input logic [LW-1:0] b);
        int n;
        bit bad;
        n   = 0;
        bad = 1'b0;
        while (!(bus.out_valid && bus.out_ready) && n < 300) begin
            if (bus.in_ready) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        if (!(bus.out_valid && bus.out_ready)) check_eq("out_wait", LW'(bus.out_valid), LW'(1));
        @(negedge clk);
        check_eq("rearm_eng_reset_n", LW'(eng_reset_n), LW'(0));
        check_eq("rearm_busy", LW'(busy), LW'(1));
        check_eq("rearm_mat_a", eng_matrix[LW-1:0], a);
        if (bus.in_ready) bad = 1'b1;
        @(negedge clk);
        check_eq("idle_eng_reset_n", LW'(eng_reset_n), LW'(1));
        check_eq("idle_in_ready", LW'(bus.in_ready), LW'(1));
        check_eq("idle_busy", LW'(busy), LW'(0));
        check_eq("idle_job_count", LW'(job_count), LW'(exp_jobs));
        check_eq("in_ready_while_busy", LW'(bad), LW'(0));
        check_eq("rearm_mat_b_kept", eng_matrix[2*LW-1:LW], b);
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [LW-1:0] a, input logic [LW-1:0] b);
        send_line(a);
        send_line(b);
        @(negedge clk);
        check_eq("start_pulse", LW'(eng_start), LW'(1));
        check_eq("start_mat_a", eng_matrix[LW-1:0], a);
        check_eq("start_mat_b", eng_matrix[2*LW-1:LW], b);
        @(negedge clk);
        check_eq("start_one_cycle", LW'(eng_start), LW'(0));
        finish_job(a, b);
    endtask

    // Called at posedge+1; holds reset for n cycles and returns at posedge+1.
    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check_eq("reset_eng_reset_n", LW'(eng_reset_n), LW'(0));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_reset_busy", LW'(busy), LW'(0));
        check_eq("post_reset_in_ready", LW'(bus.in_ready), LW'(1));
        check_eq("post_reset_job_count", LW'(job_count), LW'(0));
        check_eq("post_reset_out_valid", LW'(bus.out_valid), LW'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [LW-1:0] ident;
        logic [LW-1:0] seq;
        logic [LW-1:0] a;
        logic [LW-1:0] b;
        logic [LW-1:0] held;
        int            n;
        bit            bad;

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        hang          = 1'b0;
        glitch        = 1'b0;
        eng_lat       = 3;

        ident = '0;
        seq   = '0;
        for (int i = 0; i < 16; i++) begin
            if (i % 5 == 0) ident[i*32 +: 32] = 32'd1;
            seq[i*32 +: 32] = 32'(i + 1);
        end

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", LW'(bus.out_valid), LW'(0));
        check_eq("rst_out_data", bus.out_data, LW'(0));
        check_eq("rst_eng_start", LW'(eng_start), LW'(0));
        check_eq("rst_mat_lo", eng_matrix[LW-1:0], LW'(0));
        check_eq("rst_mat_hi", eng_matrix[2*LW-1:LW], LW'(0));
        check_eq("rst_busy", LW'(busy), LW'(0));
        check_eq("rst_job_count", LW'(job_count), LW'(0));
        check_eq("rst_timeout_err", LW'(timeout_err), LW'(0));
        check_eq("rst_eng_reset_n", LW'(eng_reset_n), LW'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("run_eng_reset_n", LW'(eng_reset_n), LW'(1));
        check_eq("run_in_ready", LW'(bus.in_ready), LW'(1));
        @(posedge clk);
        #1;

        // Identity times 1..16 returns B
        run_job(ident, seq);
        check_eq("ident_result", last_out, seq);
        check_eq("job1_count", LW'(job_count), LW'(1));

        // Back-to-back jobs
        run_job(rand_line(), rand_line());
        run_job(rand_line(), rand_line());
        check_eq("job3_count", LW'(job_count), LW'(3));

        // Stale done during start must not be captured
        glitch = 1'b1;
        run_job(rand_line(), rand_line());
        glitch = 1'b0;

        // Output stall for 20 cycles
        bus.out_ready = 1'b0;
        a = rand_line();
        b = rand_line();
        send_line(a);
        send_line(b);
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("stall_out_valid", LW'(bus.out_valid), LW'(1));
        held = bus.out_data;
        bad  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_data !== held || bus.in_ready) bad = 1'b1;
            if (job_count !== CW'(exp_jobs)) bad = 1'b1;
        end
        check_eq("stall_stable", LW'(bad), LW'(0));
        check_eq("stall_job_count", LW'(job_count), LW'(4));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        finish_job(a, b);
        check_eq("stall_done_count", LW'(job_count), LW'(5));

        // Reset after A accepted: fresh A and B afterwards
        send_line(rand_line());
        do_reset(1);
        run_job(rand_line(), rand_line());
        check_eq("after_abort_count", LW'(job_count), LW'(1));

        // Engine never finishes
        hang = 1'b1;
        send_line(rand_line());
        send_line(rand_line());
`ifdef MATRIX_TIMEOUT_EN
        n   = 0;
        bad = 1'b0;
        @(negedge clk);
        while (!timeout_err && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.out_valid) bad = 1'b1;
        end
        check_eq("timeout_latency", LW'(n), LW'(TO + 1));
        check_eq("timeout_rearm", LW'(eng_reset_n), LW'(0));
        @(negedge clk);
        check_eq("timeout_one_cycle", LW'(timeout_err), LW'(0));
        check_eq("timeout_idle", LW'(bus.in_ready), LW'(1));
        check_eq("timeout_no_output", LW'(bad), LW'(0));
        check_eq("timeout_job_count", LW'(job_count), LW'(1));
        @(posedge clk);
        #1;
        hang = 1'b0;
`else
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid || timeout_err || bus.in_ready) bad = 1'b1;
        end
        check_eq("hang_waits", LW'(bad), LW'(0));
        check_eq("hang_busy", LW'(busy), LW'(1));
        check_eq("hang_job_count", LW'(job_count), LW'(1));
        @(posedge clk);
        #1;
        hang = 1'b0;
        do_reset(2);
`endif

        // Job counter wrap with a fast engine
        do_reset(1);
        eng_lat = 1;
        for (int j = 0; j < 15; j++) run_job(rand_line(), rand_line());
        check_eq("count_max", LW'(job_count), LW'(15));
        run_job(rand_line(), rand_line());
        check_eq("count_wrap", LW'(job_count), LW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/matrix_stream_ctrl.md
MATRIX_STREAM_CTRL -- requirements
Module: matrix_stream_ctrl

Interface
REQ-001 Parameter LINE_W, default 512: width of one input/output data line in bits.
REQ-002 Parameter CNT_W, default 16: width of the completed-job counter.
REQ-003 Parameter TIMEOUT_CYC, default 1024: engine watchdog limit in cycles (used only with MATRIX_TIMEOUT_EN).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 in_valid / in_ready / in_data  in / out / LINE_W  operand-line stream; first line is A (row-major 4x4, 32-bit elements), second line is B.
REQ-007 out_valid / out_ready / out_data  out / in / LINE_W  result-line stream.
REQ-008 eng_matrix  out  2*LINE_W  operand bus to the 4x4 multiply engine; {B, A}, with A in bits [511:0].
REQ-009 eng_start  out  1  one-cycle start pulse to the engine.
REQ-010 eng_reset_n  out  1  active-low synchronous re-arm to the engine.
REQ-011 eng_done / eng_result  in / in  1 / LINE_W  engine completion flag (sticky) and product.
REQ-012 busy  out  1  high whenever state is not IDLE_A.
REQ-013 job_count  out  CNT_W  number of result lines accepted downstream.
REQ-014 timeout_err  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-015 The FSM SHALL have states IDLE_A, LOAD_B, START, WAIT, OUT and REARM.
REQ-016 in_ready SHALL be 1 only in IDLE_A and LOAD_B.
REQ-017 In IDLE_A, an in_valid&&in_ready cycle SHALL latch in_data into A and move to LOAD_B.
REQ-018 In LOAD_B, an in_valid&&in_ready cycle SHALL latch in_data into B and move to START.
REQ-019 eng_matrix SHALL be driven from the registered A/B and held stable from START until REARM exits.
REQ-020 eng_start SHALL be 1 for exactly the single START cycle, after which the FSM moves to WAIT.
REQ-021 In WAIT, eng_done=1 SHALL capture eng_result into the output register and move to OUT on the next cycle.
REQ-022 out_valid SHALL be 1 only in OUT, and out_data SHALL equal the captured register.
REQ-023 out_data SHALL hold stable while out_valid=1 and out_ready=0; stalls are unbounded.
REQ-024 On out_valid&&out_ready, job_count SHALL increment modulo 2^CNT_W (0xFFFF wraps to 0x0000) and the FSM SHALL move to REARM.
REQ-025 REARM SHALL last exactly 1 cycle with eng_reset_n=0 and then return to IDLE_A.
REQ-026 eng_reset_n SHALL otherwise be 1, except that it SHALL also be 0 whenever reset=0.
REQ-027 Latency from the second line's handshake to eng_start SHALL be 1 cycle.
REQ-028 Latency from eng_done sampled high to out_valid SHALL be 1 cycle.
REQ-029 An eng_done that is already high in START SHALL be ignored; it is sampled in WAIT only.
REQ-030 Minimum job period with no stalls SHALL be 6 cycles plus the engine latency.

Reset
REQ-031 On reset=0 the FSM SHALL go to IDLE_A, and partial A/B and any pending result SHALL be discarded.
REQ-032 On reset=0: out_valid=0, out_data=0, eng_start=0, eng_matrix=0, busy=0, job_count=0, timeout_err=0.
REQ-033 Reset asserted mid-job SHALL abort the job without incrementing job_count.

Configuration
REQ-034 With MATRIX_TIMEOUT_EN defined, a counter SHALL run in WAIT.
REQ-035 With MATRIX_TIMEOUT_EN, reaching TIMEOUT_CYC cycles without eng_done SHALL pulse timeout_err for 1 cycle and go to REARM.
REQ-036 On a timeout, no output line SHALL be produced and job_count SHALL be unchanged.
REQ-037 Without MATRIX_TIMEOUT_EN, WAIT SHALL be held indefinitely and timeout_err SHALL be tied to 0; the port remains present.

Structure
REQ-038 Package matrix_pkg SHALL hold the FSM state enum, LINE_W, ELEM_W=32, MAT_DIM=4 and the default TIMEOUT_CYC.
REQ-039 matrix_stream_ctrl SHALL be a single module with no sub-module; the watchdog is inline.

Verification
REQ-040 A = identity, B elements 1..16 -> engine sees eng_start 1 cycle after the B handshake; out_data returned equals B; job_count=1; eng_reset_n low for 1 cycle.
REQ-041 Two jobs back-to-back with out_ready=1 -> two correct results in order; in_ready=0 from START through REARM; job_count=2.
REQ-042 out_ready=0 for 20 cycles in OUT -> out_valid and out_data stable; in_ready=0; no job_count change until the handshake.
REQ-043 reset=0 for 1 cycle after A is accepted -> FSM in IDLE_A; next two lines treated as a fresh A and B; eng_reset_n=0 during reset.
REQ-044 MATRIX_TIMEOUT_EN, TIMEOUT_CYC=8, eng_done held 0 -> timeout_err pulses at WAIT cycle 8; REARM follows; no out_valid; job_count unchanged.
REQ-045 Preload job_count to 0xFFFF via 65535 fast jobs with a stub engine -> next accepted output wraps job_count to 0x0000.
